// File: rtl/voice_pool_mixer.sv
// N-voice note allocator with oldest-voice stealing and a saturating,
// attenuated sample mixer feeding one codec sample per mix.
module voice_pool_mixer #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int NOTE_WIDTH   = 6,
  parameter int DUR_WIDTH    = 6,
  parameter int ATTEN_SHIFT  = 2,
  parameter int STEAL_EN     = 1,
  parameter int MIX_TIMEOUT  = 8,
  parameter int AGE_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load_new_note,
  input  logic [NOTE_WIDTH-1:0]                note_to_load,
  input  logic [DUR_WIDTH-1:0]                 duration_to_load,
  input  logic [NUM_VOICES-1:0]                voice_playing,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voice_sample,
  input  logic [NUM_VOICES-1:0]                voice_sample_ready,
  output logic [NUM_VOICES-1:0]                voice_load,
  output logic [NOTE_WIDTH-1:0]                voice_note,
  output logic [DUR_WIDTH-1:0]                 voice_duration,
  output logic [SAMPLE_WIDTH-1:0]              sample_out,
  output logic                                 new_sample_ready,
  output logic [7:0]                           dropped_count
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int SUM_W = SAMPLE_WIDTH + $clog2(NUM_VOICES);
  localparam int TMR_W = $clog2(MIX_TIMEOUT + 1);

  logic [NUM_VOICES-1:0]   reserved_q, reserved_d;
  logic [NUM_VOICES-1:0]   voice_load_q, voice_load_d;
  logic [NUM_VOICES-1:0]   flags_q, flags_d;
  logic [NOTE_WIDTH-1:0]   note_q, note_d;
  logic [DUR_WIDTH-1:0]    dur_q, dur_d;
  logic [7:0]              dropped_q, dropped_d;
  logic [SAMPLE_WIDTH-1:0] sample_out_q, sample_out_d;
  logic                    nsr_q, nsr_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [AGE_WIDTH-1:0]    age_q [NUM_VOICES];
  logic [AGE_WIDTH-1:0]    age_d [NUM_VOICES];
  logic [SAMPLE_WIDTH-1:0] smp_q [NUM_VOICES];
  logic [SAMPLE_WIDTH-1:0] smp_d [NUM_VOICES];

  logic [NUM_VOICES-1:0] free_v, any_ready;
  logic                  free_found, req, do_load, fire;
  logic [IDX_W-1:0]      free_idx, old_idx, tgt_idx;
  logic [AGE_WIDTH-1:0]  old_age;
  logic [SAMPLE_WIDTH-1:0] cur_s;
  logic signed [SUM_W-1:0] ext_s, sum;
  logic [SAMPLE_WIDTH-1:0] sat;

  always_comb begin
    free_v     = ~voice_playing & ~reserved_q;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age_q[0];
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (free_v[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      // strict compare keeps the lowest index on equal ages
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
    req          = load_new_note && (duration_to_load != '0);
    do_load      = req && (free_found || (STEAL_EN != 0));
    tgt_idx      = free_found ? free_idx : old_idx;
    voice_load_d = do_load ? (NUM_VOICES'(1) << tgt_idx) : '0;
    note_d       = do_load ? note_to_load : note_q;
    dur_d        = do_load ? duration_to_load : dur_q;
    dropped_d    = (req && !do_load && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
    reserved_d   = (reserved_q & ~voice_playing) | voice_load_d;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (voice_load_d[i])
        age_d[i] = '0;
      else if (voice_playing[i] && age_q[i] != '1)
        age_d[i] = age_q[i] + AGE_WIDTH'(1);
      else
        age_d[i] = age_q[i];
    end
  end

  always_comb begin
    any_ready = flags_q | voice_sample_ready;
    fire      = (&any_ready) || (timer_q == TMR_W'(MIX_TIMEOUT));
    sum       = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      // a ready pulse in the fire cycle joins this mix directly
      if (voice_sample_ready[i])
        cur_s = voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      else if (flags_q[i])
        cur_s = smp_q[i];
      else
        cur_s = '0;
      smp_d[i] = voice_sample_ready[i] ? voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] : smp_q[i];
      ext_s    = {{(SUM_W-SAMPLE_WIDTH){cur_s[SAMPLE_WIDTH-1]}}, cur_s};
      sum      = sum + (ext_s >>> ATTEN_SHIFT);
    end
    if (!sum[SUM_W-1] && (|sum[SUM_W-2:SAMPLE_WIDTH-1]))
      sat = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    else if (sum[SUM_W-1] && !(&sum[SUM_W-2:SAMPLE_WIDTH-1]))
      sat = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    else
      sat = sum[SAMPLE_WIDTH-1:0];
    flags_d      = fire ? '0 : any_ready;
    timer_d      = (fire || !(|any_ready)) ? '0 : timer_q + TMR_W'(1);
    sample_out_d = fire ? sat : sample_out_q;
    nsr_d        = fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reserved_q   <= '0;
      voice_load_q <= '0;
      flags_q      <= '0;
      note_q       <= '0;
      dur_q        <= '0;
      dropped_q    <= '0;
      sample_out_q <= '0;
      nsr_q        <= 1'b0;
      timer_q      <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        age_q[i] <= '0;
        smp_q[i] <= '0;
      end
    end else begin
      reserved_q   <= reserved_d;
      voice_load_q <= voice_load_d;
      flags_q      <= flags_d;
      note_q       <= note_d;
      dur_q        <= dur_d;
      dropped_q    <= dropped_d;
      sample_out_q <= sample_out_d;
      nsr_q        <= nsr_d;
      timer_q      <= timer_d;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        age_q[i] <= age_d[i];
        smp_q[i] <= smp_d[i];
      end
    end
  end

  assign voice_load       = voice_load_q;
  assign voice_note       = note_q;
  assign voice_duration   = dur_q;
  assign sample_out       = sample_out_q;
  assign new_sample_ready = nsr_q;
  assign dropped_count    = dropped_q;
endmodule

// File: tb/tb_voice_pool_mixer.sv
// Directed bench for voice_pool_mixer: default build, no-steal build and
// unattenuated build share one stimulus stream.
module tb_voice_pool_mixer;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_new_note;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic [3:0]  voice_playing;
  logic [63:0] voice_sample;
  logic [3:0]  voice_sample_ready;

  logic [3:0]  vl_a, vl_b, vl_c;
  logic [5:0]  vn_a, vn_b, vn_c;
  logic [5:0]  vd_a, vd_b, vd_c;
  logic [15:0] so_a, so_b, so_c;
  logic        nsr_a, nsr_b, nsr_c;
  logic [7:0]  dc_a, dc_b, dc_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  always #5 clk = ~clk;

  voice_pool_mixer u_dut (
    .clk(clk), .reset(reset), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .voice_playing(voice_playing), .voice_sample(voice_sample),
    .voice_sample_ready(voice_sample_ready), .voice_load(vl_a),
    .voice_note(vn_a), .voice_duration(vd_a), .sample_out(so_a),
    .new_sample_ready(nsr_a), .dropped_count(dc_a));

  voice_pool_mixer #(.STEAL_EN(0)) u_nosteal (
    .clk(clk), .reset(reset), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .voice_playing(voice_playing), .voice_sample(voice_sample),
    .voice_sample_ready(voice_sample_ready), .voice_load(vl_b),
    .voice_note(vn_b), .voice_duration(vd_b), .sample_out(so_b),
    .new_sample_ready(nsr_b), .dropped_count(dc_b));

  voice_pool_mixer #(.ATTEN_SHIFT(0)) u_noatt (
    .clk(clk), .reset(reset), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .voice_playing(voice_playing), .voice_sample(voice_sample),
    .voice_sample_ready(voice_sample_ready), .voice_load(vl_c),
    .voice_note(vn_c), .voice_duration(vd_c), .sample_out(so_c),
    .new_sample_ready(nsr_c), .dropped_count(dc_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load_new_note = 1'b0; note_to_load = '0; duration_to_load = '0;
    voice_playing = '0; voice_sample = '0; voice_sample_ready = '0;
    tick(); tick(); tick();
    chk("rst_load", 32'(vl_a), 32'h0);
    chk("rst_note", 32'(vn_a), 32'h0);
    chk("rst_sample", 32'(so_a), 32'h0);
    chk("rst_nsr", 32'(nsr_a), 32'h0);
    chk("rst_drop", 32'(dc_b), 32'h0);
    reset = 1'b0;
    tick();

    // four spaced loads, playing echoed two cycles later
    for (int k = 0; k < 4; k++) begin
      load_new_note = 1'b1; note_to_load = 6'd10; duration_to_load = 6'd5;
      tick();
      load_new_note = 1'b0;
      chk($sformatf("spaced_load%0d", k), 32'(vl_a), 32'(4'b0001 << k));
      chk($sformatf("spaced_note%0d", k), 32'(vn_a), 32'd10);
      chk($sformatf("spaced_dur%0d", k), 32'(vd_a), 32'd5);
      tick();
      chk($sformatf("spaced_pulse_end%0d", k), 32'(vl_a), 32'h0);
      voice_playing[k] = 1'b1;
      tick(); tick();
    end

    // zero-duration request is ignored even with no voice free
    load_new_note = 1'b1; duration_to_load = 6'd0;
    tick();
    load_new_note = 1'b0;
    chk("dur0_load", 32'(vl_a), 32'h0);
    chk("dur0_drop", 32'(dc_b), 32'h0);

    // steal oldest (voice 0), then voice 1 becomes oldest
    load_new_note = 1'b1; duration_to_load = 6'd5; note_to_load = 6'd20;
    tick();
    chk("steal_first", 32'(vl_a), 32'h1);
    chk("steal_note", 32'(vn_a), 32'd20);
    chk("nosteal_load", 32'(vl_b), 32'h0);
    chk("nosteal_drop1", 32'(dc_b), 32'd1);
    tick();
    chk("steal_second", 32'(vl_a), 32'h2);
    for (int k = 0; k < 300; k++) tick();
    load_new_note = 1'b0;
    chk("drop_saturate", 32'(dc_b), 32'd255);
    chk("steal_no_drop", 32'(dc_a), 32'd0);

    reset = 1'b1; tick(); reset = 1'b0; voice_playing = '0; tick();

    // back-to-back with playing held low: reservation steers second request
    load_new_note = 1'b1; note_to_load = 6'd3; duration_to_load = 6'd7;
    tick();
    chk("b2b_first", 32'(vl_a), 32'h1);
    tick();
    chk("b2b_second", 32'(vl_a), 32'h2);
    tick();
    load_new_note = 1'b0;
    chk("b2b_third", 32'(vl_a), 32'h4);

    reset = 1'b1; tick(); reset = 1'b0; tick();

    // all four ready at full scale
    voice_sample = {4{16'h7FFF}};
    voice_sample_ready = 4'hF;
    tick();
    voice_sample_ready = '0;
    chk("sat_nsr", 32'(nsr_c), 32'h1);
    chk("sat_value", 32'(so_c), 32'h7FFF);
    chk("atten_value", 32'(so_a), 32'h7FFC);
    tick();
    chk("sat_nsr_end", 32'(nsr_c), 32'h0);
    chk("sat_hold", 32'(so_c), 32'h7FFF);

    // partial mix forced by timeout; stale samples of 2,3 must not count
    voice_sample = {16'h1234, 16'h1234, 16'hFCE0, 16'd400};
    voice_sample_ready = 4'b0011;
    tick();
    voice_sample_ready = '0;
    cnt = -1;
    for (int k = 1; k <= 20; k++) begin
      if (cnt < 0 && nsr_a) cnt = k - 1;
      if (cnt < 0) tick();
    end
    chk("timeout_latency", 32'(cnt), 32'd8);
    chk("timeout_value", 32'(so_a), 32'(16'hFF9C));
    chk("timeout_value_noatt", 32'(so_c), 32'(16'hFE70));

    // reset mid-mix
    voice_sample_ready = 4'b0001;
    tick();
    voice_sample_ready = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rstmix_nsr", 32'(nsr_a), 32'h0);
    chk("rstmix_sample", 32'(so_a), 32'h0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (nsr_a) cnt++;
    end
    chk("rstmix_no_pulse", 32'(cnt), 32'd0);

    // reset coincident with a load request
    load_new_note = 1'b1; note_to_load = 6'd33; duration_to_load = 6'd9;
    reset = 1'b1;
    tick();
    chk("rstload_load", 32'(vl_a), 32'h0);
    chk("rstload_note", 32'(vn_a), 32'h0);
    reset = 1'b0; load_new_note = 1'b0;
    tick();
    chk("rstload_after", 32'(vl_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_pool_mixer.md
Name: voice_pool_mixer

Overview:
- Parametrised N-voice allocator and mixer; next generation of the three-voice note distributor.
- Sits between the song reader and an array of NUM_VOICES external note_player instances.
- Dispatches each new note to a free voice, optionally steals the oldest voice when none is free, and counts dropped notes.
- Gathers per-voice samples and emits one saturated, attenuated mix per codec sample.

Parameters:
- NUM_VOICES, 4, number of note players served (2..8)
- SAMPLE_WIDTH, 16, signed sample width
- NOTE_WIDTH, 6, note code width
- DUR_WIDTH, 6, duration width
- ATTEN_SHIFT, 2, arithmetic right shift applied to each voice sample before summing
- STEAL_EN, 1, 1 = steal oldest voice when none is free; 0 = drop the note
- MIX_TIMEOUT, 8, cycles after the first voice-ready before a partial mix is forced
- AGE_WIDTH, 8, per-voice age counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_new_note  in  1  one-cycle request carrying a new note
- note_to_load  in  NOTE_WIDTH  note for the request
- duration_to_load  in  DUR_WIDTH  duration for the request
- voice_playing  in  NUM_VOICES  per-voice busy flags from the note players
- voice_sample  in  NUM_VOICES*SAMPLE_WIDTH  packed signed samples; voice i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- voice_sample_ready  in  NUM_VOICES  per-voice sample-valid pulses
- voice_load  out  NUM_VOICES  one-hot, one-cycle load pulse
- voice_note  out  NOTE_WIDTH  registered note driven with voice_load
- voice_duration  out  DUR_WIDTH  registered duration driven with voice_load
- sample_out  out  SAMPLE_WIDTH  signed mixed sample
- new_sample_ready  out  1  one-cycle pulse: sample_out is new
- dropped_count  out  8  notes dropped; saturates at 255

Behaviour:
- Reset values: all outputs 0; reserved, age, ready_flags, captured samples and timeout counter all cleared. Reset mid-operation aborts any pending load or partial mix with no output pulse.
- Free voice: voice_playing[i]==0 and reserved[i]==0.
- Dispatch latency is one cycle. If load_new_note is high in cycle T and duration_to_load != 0:
  - The lowest-index free voice is chosen.
  - In T+1: voice_load = one-hot of that voice; voice_note and voice_duration hold T's inputs.
  - Also in T+1: reserved[i] is set and age[i] is cleared.
- A request with duration 0 is ignored: no load pulse, no drop count.
- reserved[i] clears in the first cycle voice_playing[i]==1. This prevents a second request from landing on a voice that has not yet raised playing.
- No free voice, STEAL_EN=1: the voice with the largest age is chosen (ties go to the lowest index) and is loaded as above. The note player restarts on load.
- No free voice, STEAL_EN=0: no load pulse; dropped_count increments, saturating at 255.
- Age: age[i] increments every cycle while voice_playing[i]==1, saturating at 2^AGE_WIDTH-1, and is cleared on load.
- Back-to-back requests in T and T+1 are allowed. The T+1 decision sees the reserved bit written by T, so the two requests land on distinct voices.
- Same-cycle voice_playing fall and load_new_note: the value sampled in that cycle decides.
- Mix capture: when voice_sample_ready[i]==1, voice i's sample is captured into its register and ready_flags[i] is set.
- Mix fire condition: (ready_flags | voice_sample_ready) is all ones, or the timeout counter reaches MIX_TIMEOUT. The timeout counter starts when the first flag is set.
- Mix arithmetic, on fire:
  - sum = sum over all voices of (captured_sample >>> ATTEN_SHIFT). Voices never flagged contribute 0.
  - The sum is formed at SAMPLE_WIDTH + clog2(NUM_VOICES) bits and saturated to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - sample_out is registered and new_sample_ready pulses in the next cycle.
  - ready_flags and the timeout counter clear.
- sample_out holds its value between pulses.
- A ready pulse arriving in the same cycle as a fire belongs to the current mix and does not start a new one.

Test Plan:
- Reset, then four spaced loads (note 10, dur 5), voice_playing echoed 2 cycles after each load -> voice_load = 0001, 0010, 0100, 1000; each pulse 1 cycle after its request; voice_note = 10.
- Back-to-back loads in consecutive cycles with all voices idle and playing held low -> voice_load = 0001 then 0010 (reservation honoured).
- All four voices playing; ages forced by loading in order 0,1,2,3 -> a fifth load steals voice 0, whose age then resets. With STEAL_EN=0 instead -> no voice_load; 300 further loads leave dropped_count = 255.
- All four voices ready in one cycle with samples 0x7FFF each, ATTEN_SHIFT=0 -> sample_out = 0x7FFF (saturated), new_sample_ready high exactly one cycle later.
- Voices 0 and 1 ready with samples 400 and -800, voices 2 and 3 silent -> after 8 cycles, a timeout mix gives sample_out = 100 + (-200) = -100.
- Assert reset mid-mix and mid-dispatch -> no new_sample_ready or voice_load pulse; outputs 0 in the cycle after reset.
